// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared constants for the data-RAM arbiter
// (read-owner encoding, grant states, default starvation limit).
package dmem_arb_pkg;

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_CPU  = 2'd1;
  localparam logic [1:0] OWN_DMA  = 2'd2;

  typedef enum logic [1:0] {
    GS_IDLE = 2'd0,
    GS_CPU  = 2'd1,
    GS_DMA  = 2'd2
  } gnt_e;

  localparam int MAX_WAIT_DEF = 8;

endpackage

// File: rtl/arb_wait_counter.sv
// arb_wait_counter: saturating up-counter with synchronous clear.
// Ports: clock, reset (async low), inc, clr, sat_val -> cnt, sat.
module arb_wait_counter #(
  parameter int W = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  input  logic [W-1:0] sat_val,
  output logic [W-1:0] cnt,
  output logic         sat
);

  assign sat = (cnt == sat_val);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !sat) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the data RAM between CPU (priority) and frame-fetch DMA,
// with a starvation guard forcing one DMA grant after MAX_WAIT denials.
// Ports: clock, reset (async low); cpu_* request/stall/rdata; dma_* req/gnt/rvalid/rdata;
// ram_* RAM side. Optional DMEM_ARB_PERF_EN adds perf_cpu_cnt/perf_dma_cnt/perf_stall_cnt.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W   = 12,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_en,
  input  logic              cpu_wren,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              dma_req,
  input  logic [ADDR_W-1:0] dma_addr,
  output logic              dma_gnt,
  output logic              dma_rvalid,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              ram_wEn,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_dataIn,
  input  logic [DATA_W-1:0] ram_dataOut
`ifdef DMEM_ARB_PERF_EN
  ,
  output logic [31:0]       perf_cpu_cnt,
  output logic [31:0]       perf_dma_cnt,
  output logic [31:0]       perf_stall_cnt
`endif
);

  localparam int CW = $clog2(MAX_WAIT + 1);

  logic [CW-1:0] wait_cnt;
  logic          sat;
  logic          starve;
  logic          wait_inc;
  gnt_e          gstate;
  logic [1:0]    owner_d;
  logic [1:0]    owner_q;

  arb_wait_counter #(
    .W (CW)
  ) u_wait (
    .clock   (clock),
    .reset   (reset),
    .inc     (wait_inc),
    .clr     (!wait_inc),
    .sat_val (CW'(MAX_WAIT)),
    .cnt     (wait_cnt),
    .sat     (sat)
  );

  // The count only climbs while dma_req is held, so qualifying
  // with dma_req keeps a withdrawn request from blocking the CPU.
  assign starve   = sat & dma_req;
  assign wait_inc = dma_req & ~dma_gnt;

  // Grants are held off while reset is asserted so nothing
  // reaches the RAM or either requester during reset.
  always_comb begin
    gstate = GS_IDLE;
    if (reset) begin
      if (dma_req && (!cpu_en || starve)) begin
        gstate = GS_DMA;
      end else if (cpu_en) begin
        gstate = GS_CPU;
      end
    end
  end

  assign dma_gnt    = (gstate == GS_DMA);
  assign cpu_stall  = dma_gnt & cpu_en;
  assign ram_wEn    = (gstate == GS_CPU) & cpu_wren;
  assign ram_addr   = dma_gnt ? dma_addr : cpu_addr;
  assign ram_dataIn = cpu_wdata;

  always_comb begin
    owner_d = OWN_NONE;
    unique case (gstate)
      GS_DMA:  owner_d = OWN_DMA;
      GS_CPU:  owner_d = cpu_wren ? OWN_NONE : OWN_CPU;
      default: owner_d = OWN_NONE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      owner_q <= OWN_NONE;
    end else begin
      owner_q <= owner_d;
    end
  end

  // RAM output is registered, so the owner recorded last
  // cycle tells whose data is on ram_dataOut now.
  assign dma_rvalid = (owner_q == OWN_DMA);
  assign dma_rdata  = ram_dataOut;
  assign cpu_rdata  = ram_dataOut;

  a_wait_bound: assert property (
    @(posedge clock) disable iff (!reset)
    wait_cnt <= CW'(MAX_WAIT)
  );

`ifdef DMEM_ARB_PERF_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      perf_cpu_cnt   <= '0;
      perf_dma_cnt   <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (gstate == GS_CPU) perf_cpu_cnt <= perf_cpu_cnt + 32'd1;
      if (gstate == GS_DMA) perf_dma_cnt <= perf_dma_cnt + 32'd1;
      if (cpu_stall) perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule
